// File: rtl/sram_axi_pkg.sv
// -----------------------------------------------------------------------------
// sram_axi_pkg
//   Shared types and helpers for the SRAM-like to AXI3 bridge.
//   - state_e        : bridge FSM states
//   - owner_e        : which SRAM-like master owns the current transaction
//   - AXI_BURST_INCR : AXI3 INCR burst encoding (used with len=0, single beat)
//   - wstrb_of()     : byte-lane strobe for a sub-word store
// -----------------------------------------------------------------------------
package sram_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_AR   = 3'd1,
    S_RD_R    = 3'd2,
    S_WR_AW_W = 3'd3,
    S_WR_B    = 3'd4
  } state_e;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Byte strobe for a store: byte lanes by addr[1:0], halfwords by addr[1],
  // words (and the unused size 3) write all lanes.
  function automatic logic [3:0] wstrb_of(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << addr_lo;
      2'd1:    strb = 4'b0011 << {addr_lo[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sram_like_to_axi_if.sv
// -----------------------------------------------------------------------------
// sram_like_to_axi_if
//   AXI3 master port bundle (AR, R, AW, W, B channels) of the bridge.
//   Parameter ID_W : width of the AXI ID fields.
//   Modports:
//     master : the bridge side (drives address/write channels, rready, bready)
//     slave  : the interconnect / memory side
// -----------------------------------------------------------------------------
interface sram_like_to_axi_if #(
  parameter int ID_W = 4
) ();

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [3:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [1:0]      awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;

  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/sram_like_arb.sv
// -----------------------------------------------------------------------------
// sram_like_arb
//   Picks which SRAM-like master (inst or data) is granted when the bridge is
//   idle.
//   Ports:
//     inst_req, data_req : request lines of the two masters
//     gnt_vld            : some master is requesting
//     gnt_owner          : the winner (valid with gnt_vld)
//     clk, resetn, take  : only with SRAM_AXI_RR_ARB_EN; take pulses when the
//                          grant is accepted and updates the round-robin state
//   Configuration macro: SRAM_AXI_RR_ARB_EN
//     defined   : round-robin, the master that did not win last time wins a tie
//     undefined : fixed priority, data wins over inst
// -----------------------------------------------------------------------------
module sram_like_arb
  import sram_axi_pkg::*;
(
  input  logic   inst_req,
  input  logic   data_req,
  output logic   gnt_vld,
  output owner_e gnt_owner
`ifdef SRAM_AXI_RR_ARB_EN
  ,
  input  logic   clk,
  input  logic   resetn,
  input  logic   take
`endif
);

  assign gnt_vld = inst_req | data_req;

`ifdef SRAM_AXI_RR_ARB_EN
  owner_e last_owner_q;
  owner_e last_owner_d;

  always_comb begin
    gnt_owner = OWNER_INST;
    if (inst_req && data_req) begin
      gnt_owner = (last_owner_q == OWNER_INST) ? OWNER_DATA : OWNER_INST;
    end else if (data_req) begin
      gnt_owner = OWNER_DATA;
    end
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (take) begin
      last_owner_d = gnt_owner;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_owner_q <= OWNER_INST;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  assign gnt_owner = data_req ? OWNER_DATA : OWNER_INST;
`endif

endmodule

// File: rtl/sram_like_to_axi.sv
// -----------------------------------------------------------------------------
// sram_like_to_axi
//   Bridges the inst-side and data-side SRAM-like buses onto the CPU's single
//   AXI3 master port. One single-beat transaction is in flight at a time; inst
//   only reads, data reads or writes.
//   Parameters: ID_W (AXI ID width), INST_ID (arid of inst reads),
//               DATA_ID (arid/awid/wid of data accesses)
//   Ports:
//     clk, resetn                      : clock, asynchronous active-low reset
//     inst_req/wr/size/addr/wdata      : inst request (inst_wr is ignored)
//     inst_addr_ok/data_ok/rdata       : inst handshake and read data
//     data_req/wr/size/addr/wdata      : data request
//     data_addr_ok/data_ok/rdata       : data handshake and read data
//     axi                              : AXI3 master port (sram_like_to_axi_if)
//   Configuration macro: SRAM_AXI_RR_ARB_EN selects round-robin arbitration;
//   the default build uses fixed data-over-inst priority.
// -----------------------------------------------------------------------------
module sram_like_to_axi
  import sram_axi_pkg::*;
#(
  parameter int ID_W    = 4,
  parameter int INST_ID = 0,
  parameter int DATA_ID = 1
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  sram_like_to_axi_if.master axi
);

  localparam logic [ID_W-1:0] INST_AXI_ID = ID_W'(INST_ID);
  localparam logic [ID_W-1:0] DATA_AXI_ID = ID_W'(DATA_ID);

  state_e      state_q,   state_d;
  owner_e      owner_q,   owner_d;
  logic [31:0] addr_q,    addr_d;
  logic [1:0]  size_q,    size_d;
  logic        wr_q,      wr_d;
  logic [31:0] wdata_q,   wdata_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q,  rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q,  wvalid_d;
  logic        bready_q,  bready_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q,  w_done_d;

  logic        gnt_vld;
  owner_e      gnt_owner;
  logic        take;
  logic        rd_done;

  // Response fields, IDs and the inst write side carry no information here.
  logic        unused_inputs;
  assign unused_inputs = ^{inst_wr, inst_wdata, axi.rid, axi.rresp, axi.rlast,
                           axi.bid, axi.bresp};

  sram_like_arb u_arb (
    .inst_req  (inst_req),
    .data_req  (data_req),
    .gnt_vld   (gnt_vld),
    .gnt_owner (gnt_owner)
`ifdef SRAM_AXI_RR_ARB_EN
    ,
    .clk       (clk),
    .resetn    (resetn),
    .take      (take)
`endif
  );

  // A grant is only taken from IDLE; addr_ok is gated by resetn so a request
  // seen while reset is held never gets acknowledged.
  assign take         = (state_q == S_IDLE) && gnt_vld && resetn;
  assign inst_addr_ok = take && (gnt_owner == OWNER_INST);
  assign data_addr_ok = take && (gnt_owner == OWNER_DATA);

  // Read data passes straight through in the rvalid cycle.
  assign rd_done      = (state_q == S_RD_R) && axi.rvalid;
  assign inst_data_ok = rd_done && (owner_q == OWNER_INST);
  assign data_data_ok = (rd_done && (owner_q == OWNER_DATA)) ||
                        ((state_q == S_WR_B) && axi.bvalid);
  assign inst_rdata   = axi.rdata;
  assign data_rdata   = axi.rdata;

  assign axi.arid     = (owner_q == OWNER_DATA) ? DATA_AXI_ID : INST_AXI_ID;
  assign axi.araddr   = addr_q;
  assign axi.arlen    = 4'd0;
  assign axi.arsize   = {1'b0, size_q};
  assign axi.arburst  = AXI_BURST_INCR;
  assign axi.arlock   = 2'b00;
  assign axi.arcache  = 4'd0;
  assign axi.arprot   = 3'd0;
  assign axi.arvalid  = arvalid_q;
  assign axi.rready   = rready_q;

  // Only the data master writes, so the write channels always carry DATA_ID.
  assign axi.awid     = DATA_AXI_ID;
  assign axi.awaddr   = addr_q;
  assign axi.awlen    = 4'd0;
  assign axi.awsize   = {1'b0, size_q};
  assign axi.awburst  = AXI_BURST_INCR;
  assign axi.awlock   = 2'b00;
  assign axi.awcache  = 4'd0;
  assign axi.awprot   = 3'd0;
  assign axi.awvalid  = awvalid_q;
  assign axi.wid      = DATA_AXI_ID;
  assign axi.wdata    = wdata_q;
  assign axi.wstrb    = wstrb_of(size_q, addr_q[1:0]);
  assign axi.wlast    = 1'b1;
  assign axi.wvalid   = wvalid_q;
  assign axi.bready   = bready_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    case (state_q)
      S_IDLE: begin
        if (take) begin
          owner_d = gnt_owner;
          if (gnt_owner == OWNER_DATA) begin
            addr_d  = data_addr;
            size_d  = data_size;
            wr_d    = data_wr;
            wdata_d = data_wdata;
          end else begin
            addr_d  = inst_addr;
            size_d  = inst_size;
            wr_d    = 1'b0;
            wdata_d = 32'd0;
          end
          if ((gnt_owner == OWNER_DATA) && data_wr) begin
            state_d   = S_WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = S_RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end

      S_RD_AR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_R;
        end
      end

      S_RD_R: begin
        if (axi.rvalid) begin
          rready_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      S_WR_AW_W: begin
        // AW and W complete independently; B is accepted only after both.
        if (awvalid_q && axi.awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && axi.wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_B;
        end
      end

      S_WR_B: begin
        if (axi.bvalid) begin
          bready_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      owner_q   <= OWNER_INST;
      addr_q    <= 32'd0;
      size_q    <= 2'd0;
      wr_q      <= 1'b0;
      wdata_q   <= 32'd0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_sram_like_to_axi.sv
// -----------------------------------------------------------------------------
// tb_sram_like_to_axi
//   Self-checking bench for sram_like_to_axi. A transaction-level reference
//   model (one outstanding access, arbitration rule, AXI slave with per-channel
//   delays) predicts every handshake and field each cycle.
//   Honors SRAM_AXI_RR_ARB_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_sram_like_to_axi;
  import sram_axi_pkg::*;

  localparam int ID_W = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;

  sram_like_to_axi_if #(.ID_W(ID_W)) axi ();

  sram_like_to_axi #(.ID_W(ID_W), .INST_ID(0), .DATA_ID(1)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .axi          (axi)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Master request state, index 0 = inst, 1 = data
  bit          mq_pend [2];
  logic [31:0] mq_addr [2];
  logic [1:0]  mq_size [2];
  bit          mq_wr   [2];
  logic [31:0] mq_wdata[2];
  bit          auto_req = 0;
  bit          hold_req = 0;
  int          req_pct  = 40;

  // Transaction model
  bit          busy = 0, t_wr = 0, ar_done = 0, aw_done = 0, w_done = 0;
  int          t_own = 0;
  logic [31:0] t_addr = 0, t_wdata = 0, rd_value = 0;
  logic [1:0]  t_size = 0;
  int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
  int          k_ar = 0, k_r = 0, k_aw = 0, k_w = 0, k_b = 0;
  bit          rnd_knobs = 0, fixed_rd = 0, force_rvalid = 0;
  logic [31:0] fixed_rdata = 0;
  int          last_own = 0;
  int          cyc = 0, gnt_cyc = 0, done_cyc = 0, aw_cyc = 0, w_cyc = 0;
  int          grant_log[$];
  logic [31:0] last_araddr, last_inst_rdata;
  logic [2:0]  last_arsize, last_awsize;
  logic [3:0]  last_arid, last_wstrb;

  function automatic logic [3:0] exp_wstrb(input logic [1:0] size, input logic [31:0] addr);
    int lane;
    lane = int'(addr % 4);
    if (size == 2'd0) return 4'(1 << lane);
    if (size == 2'd1) return (lane >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  task automatic random_req(input int m);
    mq_pend[m]  = 1;
    mq_addr[m]  = $urandom;
    mq_size[m]  = 2'($urandom_range(0, 3));
    mq_wr[m]    = 1'($urandom_range(0, 1));
    mq_wdata[m] = $urandom;
  endtask

  task automatic issue(input int m, input logic [31:0] a, input logic [1:0] s,
                       input bit w, input logic [31:0] d);
    mq_pend[m] = 1; mq_addr[m] = a; mq_size[m] = s; mq_wr[m] = w; mq_wdata[m] = d;
  endtask

  task automatic step();
    logic [8:0] exp_ctrl, got_ctrl;
    int  gnt;
    bit  rv, bv, ar_hs, r_hs, aw_hs, w_hs, b_hs;
    @(posedge clk);
    cyc++;
    #1;
    if (auto_req) begin
      for (int m = 0; m < 2; m++)
        if (!mq_pend[m] && $urandom_range(0, 99) < req_pct) random_req(m);
    end
    inst_req = mq_pend[0]; inst_addr = mq_addr[0]; inst_size = mq_size[0];
    inst_wr  = mq_wr[0];   inst_wdata = mq_wdata[0];
    data_req = mq_pend[1]; data_addr = mq_addr[1]; data_size = mq_size[1];
    data_wr  = mq_wr[1];   data_wdata = mq_wdata[1];

    axi.arready = busy && !t_wr && !ar_done && (ar_wait >= k_ar);
    rv          = busy && !t_wr && ar_done && (r_wait >= k_r);
    axi.rvalid  = rv || force_rvalid;
    axi.rdata   = rv ? rd_value : $urandom;
    axi.rid     = 4'($urandom);
    axi.rresp   = 2'($urandom);
    axi.rlast   = 1'b1;
    axi.awready = busy && t_wr && !aw_done && (aw_wait >= k_aw);
    axi.wready  = busy && t_wr && !w_done && (w_wait >= k_w);
    bv          = busy && t_wr && aw_done && w_done && (b_wait >= k_b);
    axi.bvalid  = bv;
    axi.bid     = 4'($urandom);
    axi.bresp   = 2'($urandom);
    #3;

    gnt = -1;
    if (!busy && resetn) begin
      if (mq_pend[0] && mq_pend[1]) begin
`ifdef SRAM_AXI_RR_ARB_EN
        gnt = (last_own == 0) ? 1 : 0;
`else
        gnt = 1;
`endif
      end else if (mq_pend[1]) gnt = 1;
      else if (mq_pend[0]) gnt = 0;
    end
    ar_hs = busy && !t_wr && !ar_done && axi.arready;
    r_hs  = busy && !t_wr && ar_done && rv;
    aw_hs = busy && t_wr && !aw_done && axi.awready;
    w_hs  = busy && t_wr && !w_done && axi.wready;
    b_hs  = busy && t_wr && aw_done && w_done && bv;

    exp_ctrl = {busy && !t_wr && !ar_done, busy && !t_wr && ar_done,
                busy && t_wr && !aw_done, busy && t_wr && !w_done,
                busy && t_wr && aw_done && w_done,
                gnt == 0, gnt == 1, r_hs && t_own == 0, (r_hs && t_own == 1) || b_hs};
    got_ctrl = {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready,
                inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};
    chk("ctrl", 64'(got_ctrl), 64'(exp_ctrl));

    if (ar_hs) begin
      chk("ar_fields",
          64'({axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot}),
          64'({4'(t_own), t_addr, 4'd0, 1'b0, t_size, 2'b01, 2'b00, 4'd0, 3'd0}));
      last_araddr = axi.araddr; last_arsize = axi.arsize; last_arid = axi.arid;
    end
    if (r_hs) begin
      chk("rdata", 64'((t_own == 0) ? inst_rdata : data_rdata), 64'(rd_value));
      if (t_own == 0) last_inst_rdata = inst_rdata;
    end
    if (aw_hs) begin
      chk("aw_fields",
          64'({axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot}),
          64'({4'd1, t_addr, 4'd0, 1'b0, t_size, 2'b01, 2'b00, 4'd0, 3'd0}));
      last_awsize = axi.awsize;
    end
    if (w_hs) begin
      chk("w_fields", 64'({axi.wid, axi.wdata, axi.wstrb, axi.wlast}),
          64'({4'd1, t_wdata, exp_wstrb(t_size, t_addr), 1'b1}));
      last_wstrb = axi.wstrb;
    end

    if (busy) begin
      if (!t_wr) begin
        if (!ar_done) begin
          if (ar_hs) ar_done = 1; else ar_wait++;
        end else begin
          if (r_hs) begin busy = 0; done_cyc = cyc; end else r_wait++;
        end
      end else if (aw_done && w_done) begin
        if (b_hs) begin busy = 0; done_cyc = cyc; end else b_wait++;
      end else begin
        if (!aw_done) begin if (aw_hs) begin aw_done = 1; aw_cyc = cyc; end else aw_wait++; end
        if (!w_done)  begin if (w_hs)  begin w_done = 1;  w_cyc = cyc;  end else w_wait++;  end
      end
    end else if (gnt >= 0) begin
      busy = 1; t_own = gnt; t_addr = mq_addr[gnt]; t_size = mq_size[gnt];
      t_wr = (gnt == 1) ? mq_wr[1] : 1'b0; t_wdata = mq_wdata[gnt];
      ar_done = 0; aw_done = 0; w_done = 0;
      ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
      if (rnd_knobs) begin
        k_ar = $urandom_range(0, 3); k_r = $urandom_range(0, 3);
        k_aw = $urandom_range(0, 3); k_w = $urandom_range(0, 3); k_b = $urandom_range(0, 3);
      end
      rd_value = fixed_rd ? fixed_rdata : $urandom;
      last_own = gnt; gnt_cyc = cyc; grant_log.push_back(gnt);
      if (hold_req) random_req(gnt); else mq_pend[gnt] = 0;
    end
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((busy || mq_pend[0] || mq_pend[1]) && n < budget) begin
      step();
      n++;
    end
    chk("idle_bound", 64'(busy || mq_pend[0] || mq_pend[1]), 64'd0);
  endtask

  initial begin
    int n;
    resetn = 0;
    for (int m = 0; m < 2; m++) begin
      mq_pend[m] = 0; mq_addr[m] = 0; mq_size[m] = 0; mq_wr[m] = 0; mq_wdata[m] = 0;
    end
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rid = 0; axi.rresp = 0; axi.rlast = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bid = 0; axi.bresp = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ctrl", 64'({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready,
                         inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 64'd0);
    chk("rst_araddr", 64'(axi.araddr), 64'd0);
    resetn = 1;

    // Boot fetch: arready at once, rvalid on the third RD_R cycle
    k_ar = 0; k_r = 2; fixed_rd = 1; fixed_rdata = 32'h3C1DA000;
    issue(0, 32'hBFC00000, 2'd2, 1'b0, 32'd0);
    run_idle(20);
    chk("t1_latency", 64'(done_cyc - gnt_cyc), 64'd4);
    chk("t1_araddr", 64'(last_araddr), 64'hBFC00000);
    chk("t1_arsize", 64'(last_arsize), 64'd2);
    chk("t1_arid", 64'(last_arid), 64'd0);
    chk("t1_rdata", 64'(last_inst_rdata), 64'h3C1DA000);
    fixed_rd = 0;

    // Both request together: data first, inst on the next idle
    k_r = 0;
    grant_log.delete();
    issue(0, 32'h1000_0040, 2'd2, 1'b0, 32'd0);
    issue(1, 32'h2000_0080, 2'd2, 1'b0, 32'd0);
    run_idle(30);
    chk("t2_gnt0", 64'(grant_log[0]), 64'd1);
    chk("t2_gnt1", 64'(grant_log[1]), 64'd0);

    // Both held high across several grants
    grant_log.delete();
    hold_req = 1;
    issue(0, 32'h1000_0100, 2'd2, 1'b0, 32'd0);
    issue(1, 32'h2000_0100, 2'd2, 1'b0, 32'd0);
    n = 0;
    while (grant_log.size() < 4 && n < 100) begin step(); n++; end
    hold_req = 0;
    mq_pend[0] = 0; mq_pend[1] = 0;
    run_idle(30);
    chk("t2_hold_cnt", 64'(grant_log.size() >= 4), 64'd1);
`ifdef SRAM_AXI_RR_ARB_EN
    chk("t2_rr", 64'({grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]}), 64'b1010);
`else
    chk("t2_fixed", 64'({grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]}), 64'b1111);
`endif

    // Byte store then halfword store
    k_aw = 0; k_w = 0; k_b = 0;
    issue(1, 32'h80000003, 2'd0, 1'b1, 32'h000000AB);
    run_idle(20);
    chk("t3_sb_wstrb", 64'(last_wstrb), 64'b1000);
    chk("t3_sb_awsize", 64'(last_awsize), 64'd0);
    issue(1, 32'h80000002, 2'd1, 1'b1, 32'hCDEF0000);
    run_idle(20);
    chk("t3_sh_wstrb", 64'(last_wstrb), 64'b1100);

    // W accepted two cycles before AW
    k_aw = 2; k_w = 0; k_b = 1;
    issue(1, 32'h8000_1000, 2'd2, 1'b1, 32'h1234_5678);
    run_idle(20);
    chk("t4_w_before_aw", 64'(aw_cyc - w_cyc), 64'd2);

    // AW and W together in the first cycle: data_ok two cycles after addr_ok
    k_aw = 0; k_w = 0; k_b = 0;
    issue(1, 32'h8000_2000, 2'd2, 1'b1, 32'h8765_4321);
    run_idle(20);
    chk("t5_latency", 64'(done_cyc - gnt_cyc), 64'd2);

    // Reset while waiting for R
    k_ar = 0; k_r = 10;
    issue(0, 32'h0000_4000, 2'd2, 1'b0, 32'd0);
    n = 0;
    while (!(busy && ar_done) && n < 20) begin step(); n++; end
    step();
    #2;
    resetn = 0;
    #1;
    chk("t6_rst_ctrl", 64'({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready,
                            inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 64'd0);
    busy = 0; last_own = 0; mq_pend[0] = 0; mq_pend[1] = 0;
    @(negedge clk);
    resetn = 1;
    force_rvalid = 1;
    repeat (4) step();
    force_rvalid = 0;

    // Randomized traffic
    auto_req = 1; rnd_knobs = 1; req_pct = 40;
    repeat (2000) step();
    auto_req = 0;
    run_idle(100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
